lc2k_reg_file: RTL and testbench

// - LC2K architectural register file: 8 x 32-bit registers, two combinational read ports, one write port.
// - Sits directly downstream of the write-data mux; wr_data is its write_value, sampled on the posedge.
// - Write-to-read bypass lets decode see a same-cycle writeback.
// - Serial dump engine with valid/ready handshake streams all registers to a state printer/bench on halt.

---
 rtl/lc2k_pkg.sv | 14 +
 rtl/lc2k_reg_file_if.sv | 30 +++
 rtl/lc2k_reg_dump_fsm.sv | 66 ++++++
 rtl/lc2k_reg_file.sv | 59 +++++
 tb/tb_lc2k_reg_file.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lc2k_pkg.sv
// Shared sizing constants and dump-engine state type for the LC2K register file.
package lc2k_pkg;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } dump_state_t;

endpackage

// File: rtl/lc2k_reg_file_if.sv
// Write, read and dump-stream signals of the LC2K register file.
interface lc2k_reg_file_if;
  import lc2k_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              dump_start;
  logic              dump_ready;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_done;
  logic              busy;

  modport master (
    output wr_en, wr_reg, wr_data, rd_addr_a, rd_addr_b, dump_start, dump_ready,
    input  rd_data_a, rd_data_b, dump_valid, dump_idx, dump_data, dump_done, busy
  );

  modport slave (
    input  wr_en, wr_reg, wr_data, rd_addr_a, rd_addr_b, dump_start, dump_ready,
    output rd_data_a, rd_data_b, dump_valid, dump_idx, dump_data, dump_done, busy
  );

endinterface

// File: rtl/lc2k_reg_dump_fsm.sv
// Serial dump engine: streams every register as a valid/ready beat, then pulses done.
module lc2k_reg_dump_fsm
  import lc2k_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       dump_start,
  input  logic                       dump_ready,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       dump_valid,
  output logic [ADDR_W-1:0]          dump_idx,
  output logic [DATA_W-1:0]          dump_data,
  output logic                       dump_done,
  output logic                       busy
);

  dump_state_t       state;
  logic [ADDR_W-1:0] next_idx;

  assign next_idx = dump_idx + ADDR_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the beat therefore captures the pre-write register value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
      dump_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_start) begin
            state      <= DUMP;
            dump_valid <= 1'b1;
            dump_idx   <= '0;
            dump_data  <= regs_flat[0 +: DATA_W];
            busy       <= 1'b1;
          end
        end
        DUMP: begin
          // A held beat keeps its captured data; dump_start is ignored here.
          if (dump_valid && dump_ready) begin
            if (dump_idx == ADDR_W'(NUM_REGS - 1)) begin
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
              state      <= DONE;
            end else begin
              dump_idx  <= next_idx;
              dump_data <= regs_flat[next_idx*DATA_W +: DATA_W];
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lc2k_reg_file.sv
// LC2K architectural register file: r0 hardwired to zero, write-to-read bypass,
// and a serial dump port for end-of-run state printing.
module lc2k_reg_file
  import lc2k_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  lc2k_reg_file_if.slave bus
);

  logic [DATA_W-1:0]          regs [NUM_REGS];
  logic [NUM_REGS*DATA_W-1:0] regs_flat;

  // NOTE: the array is small enough to live in flops, so it is reset like any
  // other state; a RAM-mapped array would leave it out of the reset branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (bus.wr_en && bus.wr_reg != '0) begin
      regs[bus.wr_reg] <= bus.wr_data;
    end
  end

  // NOTE: each combinational output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    bus.rd_data_a = regs[bus.rd_addr_a];
    if (bus.rd_addr_a == '0)
      bus.rd_data_a = '0;
    else if (bus.wr_en && bus.wr_reg == bus.rd_addr_a)
      bus.rd_data_a = bus.wr_data;
  end

  always_comb begin
    bus.rd_data_b = regs[bus.rd_addr_b];
    if (bus.rd_addr_b == '0)
      bus.rd_data_b = '0;
    else if (bus.wr_en && bus.wr_reg == bus.rd_addr_b)
      bus.rd_data_b = bus.wr_data;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end

  lc2k_reg_dump_fsm u_dump (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump_start (bus.dump_start),
    .dump_ready (bus.dump_ready),
    .regs_flat  (regs_flat),
    .dump_valid (bus.dump_valid),
    .dump_idx   (bus.dump_idx),
    .dump_data  (bus.dump_data),
    .dump_done  (bus.dump_done),
    .busy       (bus.busy)
  );

endmodule

// File: tb/tb_lc2k_reg_file.sv
// Randomised bench for lc2k_reg_file: array model for reads, queue scoreboard for dump beats.
module tb_lc2k_reg_file;
  import lc2k_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lc2k_reg_file_if bus ();

  lc2k_reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          is_done;
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [NUM_REGS];
  int          checks = 0;
  int          passed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic fail(input string name, input int got);
    checks++;
    $display("FAIL %s: got %0d with nothing expected", name, got);
  endtask

  // Scoreboard monitor: compares every accepted beat and every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.dump_valid && bus.dump_ready) begin
        if (exp_q.size() == 0) fail("extra_beat", int'(bus.dump_idx));
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("beat_kind", 32'(bus.dump_valid && e.is_done), 32'd0);
          check("beat_idx", 32'(bus.dump_idx), 32'(e.idx));
          check("beat_data", bus.dump_data, e.data);
        end
      end
      if (bus.dump_done) begin
        if (exp_q.size() == 0) fail("extra_done", 1);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_kind", 32'(e.is_done), 32'd1);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_read(input int addr, input bit wen, input int wreg,
                                           input logic [31:0] wdata);
    if (addr == 0) return 32'd0;
    if (wen && wreg == addr) return wdata;
    return model[addr];
  endfunction

  task automatic write_and_check(input int r, input logic [31:0] d, input int other);
    bus.wr_en     = 1'b1;
    bus.wr_reg    = ADDR_W'(r);
    bus.wr_data   = d;
    bus.rd_addr_a = ADDR_W'(r);
    bus.rd_addr_b = ADDR_W'(other);
    #1;
    check("rd_a_wr", bus.rd_data_a, ref_read(r, 1'b1, r, d));
    check("rd_b_wr", bus.rd_data_b, ref_read(other, 1'b1, r, d));
    tick();
    if (r != 0) model[r] = d;
    bus.wr_en = 1'b0;
  endtask

  task automatic push_snapshot;
    for (int i = 0; i < NUM_REGS; i++) exp_q.push_back('{1'b0, i, model[i]});
    exp_q.push_back('{1'b1, 0, 32'd0});
  endtask

  task automatic run_dump(input bit always_ready, output int busy_cycles);
    push_snapshot();
    bus.dump_start = 1'b1;
    bus.dump_ready = always_ready ? 1'b1 : 1'($urandom_range(0, 1));
    tick();
    bus.dump_start = 1'b0;
    busy_cycles = 0;
    while (bus.busy && busy_cycles < 200) begin
      busy_cycles++;
      tick();
      bus.dump_ready = always_ready ? 1'b1 : 1'($urandom_range(0, 1));
    end
    if (busy_cycles >= 200) fail("dump_timeout", busy_cycles);
    bus.dump_ready = 1'b0;
    check("dump_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_idx(input int target);
    int n = 0;
    while (!(bus.dump_valid && int'(bus.dump_idx) == target) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) fail("wait_idx_timeout", target);
  endtask

  int cyc;

  initial begin
    bus.wr_en = 1'b0; bus.wr_reg = '0; bus.wr_data = '0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    bus.dump_start = 1'b0; bus.dump_ready = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'd0;

    tick(); tick();
    rst_n = 1'b1;
    check("rst_valid", 32'(bus.dump_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.dump_done), 32'd0);
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.rd_addr_a = ADDR_W'(i);
      bus.rd_addr_b = ADDR_W'(NUM_REGS - 1 - i);
      #1;
      check("rst_rd_a", bus.rd_data_a, 32'd0);
      check("rst_rd_b", bus.rd_data_b, 32'd0);
    end

    // r0 ignores writes.
    write_and_check(0, 32'hFFFF_FFFF, 0);
    bus.rd_addr_a = '0;
    #1;
    check("r0_zero", bus.rd_data_a, 32'd0);

    // Bypass, then the stored value.
    write_and_check(3, 32'h0000_1234, 3);
    bus.rd_addr_a = 3'd3;
    #1;
    check("r3_stored", bus.rd_data_a, 32'h0000_1234);

    for (int i = 1; i < NUM_REGS; i++) write_and_check(i, 32'(i), $urandom_range(0, NUM_REGS - 1));
    run_dump(1'b1, cyc);
    check("busy_cycles", 32'(cyc), 32'd9);

    // Held beat at idx 2, write to r2 and a stray dump_start during the hold.
    push_snapshot();
    bus.dump_start = 1'b1;
    bus.dump_ready = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    wait_idx(2);
    bus.dump_ready = 1'b0;
    for (int h = 0; h < 3; h++) begin
      check("hold_idx", 32'(bus.dump_idx), 32'd2);
      check("hold_data", bus.dump_data, 32'd2);
      if (h == 0) begin
        bus.wr_en = 1'b1; bus.wr_reg = 3'd2; bus.wr_data = 32'h55;
      end
      if (h == 1) bus.dump_start = 1'b1;
      tick();
      if (h == 0) model[2] = 32'h55;
      bus.wr_en = 1'b0;
      bus.dump_start = 1'b0;
    end
    check("hold_idx_last", 32'(bus.dump_idx), 32'd2);
    check("hold_data_last", bus.dump_data, 32'd2);
    bus.dump_ready = 1'b1;
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      tick();
      cyc++;
    end
    bus.dump_ready = 1'b1;
    repeat (5) tick();
    check("hold_drained", 32'(exp_q.size()), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    bus.dump_ready = 1'b0;

    // Random writes with random read addresses on both ports.
    for (int k = 0; k < 60; k++) begin
      bit          wen  = 1'($urandom_range(0, 1));
      int          wreg = $urandom_range(0, NUM_REGS - 1);
      int          ra   = $urandom_range(0, NUM_REGS - 1);
      int          rb   = (k % 5 == 0) ? wreg : $urandom_range(0, NUM_REGS - 1);
      logic [31:0] wd   = $urandom();
      bus.wr_en = wen; bus.wr_reg = ADDR_W'(wreg); bus.wr_data = wd;
      bus.rd_addr_a = ADDR_W'(ra); bus.rd_addr_b = ADDR_W'(rb);
      #1;
      check("rnd_rd_a", bus.rd_data_a, ref_read(ra, wen, wreg, wd));
      check("rnd_rd_b", bus.rd_data_b, ref_read(rb, wen, wreg, wd));
      tick();
      if (wen && wreg != 0) model[wreg] = wd;
    end
    bus.wr_en = 1'b0;
    run_dump(1'b0, cyc);

    // Reset mid-dump at idx 4.
    push_snapshot();
    bus.dump_start = 1'b1;
    bus.dump_ready = 1'b1;
    tick();
    bus.dump_start = 1'b0;
    wait_idx(4);
    rst_n = 1'b0;
    bus.dump_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'd0;
    check("abort_valid", 32'(bus.dump_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.rd_addr_a = ADDR_W'(i);
      #1;
      check("abort_regs", bus.rd_data_a, 32'd0);
    end
    repeat (5) tick();
    run_dump(1'b1, cyc);
    check("fresh_busy_cycles", 32'(cyc), 32'd9);
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
